// File: rtl/mmu_pkg.sv
// Shared definitions for the tile sequencer: FSM state encoding and watchdog defaults.
package mmu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } seq_state_t;

    localparam int DEF_COUNT_NUM   = 16;
    localparam int DEF_TILE_W      = 8;
    localparam int DEF_TIMEOUT_CYC = 4 * DEF_COUNT_NUM;

    // The watchdog allows several full counter operations before declaring a hang.
    function automatic int timeout_default(input int count_num);
        return 4 * count_num;
    endfunction

endpackage

// File: rtl/mmu_seq_wdog.sv
// WAIT-state watchdog: counts enabled cycles since the last clear and flags the
// cycle on which the count reaches TIMEOUT_CYC.
module mmu_seq_wdog
    import mmu_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (enable && (cnt_reg != LAST_CNT)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Count k is held during the (k+1)-th enabled cycle, so LAST_CNT marks the TIMEOUT_CYC-th one.
    assign expire = enable & (cnt_reg == LAST_CNT);

endmodule

// File: rtl/mmu_seq_ctrl.sv
// Tile sequencer: issues one start pulse per tile to an attached counter and tracks completions.
// Optional WAIT watchdog compiled in with `define MMU_SEQ_WATCHDOG_EN.
module mmu_seq_ctrl
    import mmu_pkg::*;
#(
    parameter int COUNT_NUM   = DEF_COUNT_NUM,
    parameter int TILE_W      = DEF_TILE_W,
    parameter int TIMEOUT_CYC = timeout_default(COUNT_NUM)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid_i,
    input  logic [TILE_W-1:0] cmd_tiles_i,
    output logic              cmd_ready_o,
    input  logic              abort_i,
    output logic              start_o,
    input  logic              done_i,
    output logic              busy_o,
    output logic [TILE_W-1:0] tile_cnt_o,
    output logic              all_done_o,
    output logic              err_o
);

    seq_state_t        state_reg, state_next;
    logic [TILE_W-1:0] remaining_reg, remaining_next;
    logic [TILE_W-1:0] tile_cnt_reg, tile_cnt_next;
    logic              alive_reg;
    logic              accept;

`ifdef MMU_SEQ_WATCHDOG_EN
    logic err_reg, err_next;
    logic wdog_expire;

    mmu_seq_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_reg != WAIT),
        .enable (state_reg == WAIT),
        .expire (wdog_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end

    assign err_o = err_reg;
`else
    assign err_o = 1'b0;
`endif

    assign accept = cmd_valid_i & cmd_ready_o;

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        tile_cnt_next  = tile_cnt_reg;
`ifdef MMU_SEQ_WATCHDOG_EN
        err_next       = err_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    remaining_next = cmd_tiles_i;
                    tile_cnt_next  = '0;
`ifdef MMU_SEQ_WATCHDOG_EN
                    err_next       = 1'b0;
`endif
                    state_next     = (cmd_tiles_i == '0) ? FINISH : ISSUE;
                end
            end
            ISSUE: begin
                state_next = abort_i ? IDLE : WAIT;
            end
            WAIT: begin
                // Abort outranks a completion arriving in the same cycle.
                if (abort_i) begin
                    state_next = IDLE;
                end else if (done_i) begin
                    tile_cnt_next  = tile_cnt_reg + 1'b1;
                    remaining_next = remaining_reg - 1'b1;
                    state_next     = (remaining_reg == TILE_W'(1)) ? FINISH : ISSUE;
                end
`ifdef MMU_SEQ_WATCHDOG_EN
                else if (wdog_expire) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end
`endif
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            tile_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            tile_cnt_reg  <= tile_cnt_next;
        end
    end

    // Keeps cmd_ready_o low during reset even though the state register sits in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive_reg <= 1'b0;
        end else begin
            alive_reg <= 1'b1;
        end
    end

    assign cmd_ready_o = (state_reg == IDLE) & alive_reg;
    assign start_o     = (state_reg == ISSUE);
    assign all_done_o  = (state_reg == FINISH);
    assign busy_o      = (state_reg != IDLE);
    assign tile_cnt_o  = tile_cnt_reg;

endmodule

// File: tb/tb_mmu_seq_ctrl.sv
// Scoreboard bench for mmu_seq_ctrl: expected start/all_done pulses are queued as stimulus is
// driven and checked by a monitor when the DUT produces them.
module tb_mmu_seq_ctrl;

    localparam int TILE_W = 8;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid_i;
    logic [TILE_W-1:0] cmd_tiles_i;
    logic              cmd_ready_o;
    logic              abort_i;
    logic              start_o;
    logic              done_i;
    logic              busy_o;
    logic [TILE_W-1:0] tile_cnt_o;
    logic              all_done_o;
    logic              err_o;

    mmu_seq_ctrl #(
        .COUNT_NUM   (16),
        .TILE_W      (TILE_W),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid_i (cmd_valid_i),
        .cmd_tiles_i (cmd_tiles_i),
        .cmd_ready_o (cmd_ready_o),
        .abort_i     (abort_i),
        .start_o     (start_o),
        .done_i      (done_i),
        .busy_o      (busy_o),
        .tile_cnt_o  (tile_cnt_o),
        .all_done_o  (all_done_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_done;
        int cyc;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end else begin
            $display("ok   %s: %0d (cycle %0d)", tag, got, cyc);
        end
    endtask

    task automatic push_exp(input bit is_done, input int cnt);
        exp_t e;
        e.is_done = is_done;
        e.cyc     = cyc + 1;
        e.cnt     = cnt;
        exp_q.push_back(e);
    endtask

    // Every start/all_done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && (start_o || all_done_o)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, all_done_o, start_o}, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.is_done ? "all_done_pulse" : "start_pulse",
                      {30'd0, all_done_o, start_o}, e.is_done ? 2 : 1);
                check("pulse_cycle", cyc, e.cyc);
                if (e.is_done) check("done_tile_cnt", tile_cnt_o, e.cnt);
            end
        end
    end

    // Called at a negedge in IDLE; returns at the negedge of the ISSUE or FINISH cycle.
    task automatic send_cmd(input int tiles);
        logic [TILE_W-1:0] t;
        t = TILE_W'(tiles);
        cmd_valid_i = 1'b1;
        cmd_tiles_i = t;
        push_exp(tiles == 0, 0);
        @(negedge clk);
        cmd_valid_i = 1'b0;
        check("ready_low_busy", cmd_ready_o, 0);
    endtask

    // Called at a negedge in WAIT; returns in WAIT (not last) or at the FINISH negedge (last).
    task automatic tile_done(input int exp_cnt, input bit last, input int gap);
        repeat (gap) @(negedge clk);
        done_i = 1'b1;
        push_exp(last, exp_cnt);
        @(negedge clk);
        done_i = 1'b0;
        check("tile_cnt", tile_cnt_o, exp_cnt);
        if (!last) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},    cmd_ready_o, 0);
        check({tag, "_busy"},     busy_o, 0);
        check({tag, "_start"},    start_o, 0);
        check({tag, "_all_done"}, all_done_o, 0);
        check({tag, "_tile_cnt"}, tile_cnt_o, 0);
        check({tag, "_err"},      err_o, 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_tiles_i = '0;
        abort_i     = 1'b0;
        done_i      = 1'b0;

        // Reset state and release
        repeat (2) @(negedge clk);
        check_all_zero("rst");
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", cmd_ready_o, 0);
        @(negedge clk);
        check("ready_after_rst", cmd_ready_o, 1);

        // Three tiles
        send_cmd(3);
        @(negedge clk);
        for (int i = 1; i <= 3; i++) tile_done(i, i == 3, 1);
        @(negedge clk);
        check("ready_after_3", cmd_ready_o, 1);
        check("hold_cnt_3", tile_cnt_o, 3);

        // done_i in IDLE and in ISSUE is ignored
        done_i = 1'b1;
        @(negedge clk);
        done_i = 1'b0;
        check("idle_done_cnt", tile_cnt_o, 3);
        check("idle_done_busy", busy_o, 0);
        send_cmd(2);
        done_i = 1'b1;
        @(negedge clk);
        done_i = 1'b0;
        check("issue_done_cnt", tile_cnt_o, 0);
        check("issue_done_busy", busy_o, 1);
        tile_done(1, 1'b0, 1);
        tile_done(2, 1'b1, 0);
        @(negedge clk);
        check("ready_after_2", cmd_ready_o, 1);

        // Zero tiles: no start, all_done right after accept
        send_cmd(0);
        check("zero_no_start", start_o, 0);
        @(negedge clk);
        check("zero_ready_back", cmd_ready_o, 1);
        check("zero_cnt", tile_cnt_o, 0);

        // Abort together with the second done of four
        send_cmd(4);
        @(negedge clk);
        tile_done(1, 1'b0, 0);
        abort_i = 1'b1;
        done_i  = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        done_i  = 1'b0;
        check("abort_busy", busy_o, 0);
        check("abort_ready", cmd_ready_o, 1);
        check("abort_cnt", tile_cnt_o, 1);
        repeat (3) @(negedge clk);
        check("abort_cnt_hold", tile_cnt_o, 1);

        // Watchdog
        send_cmd(1);
        @(negedge clk);
`ifdef MMU_SEQ_WATCHDOG_EN
        repeat (63) @(negedge clk);
        check("wd_err_pre", err_o, 0);
        check("wd_busy_pre", busy_o, 1);
        @(negedge clk);
        check("wd_err_set", err_o, 1);
        check("wd_busy_clr", busy_o, 0);
        repeat (3) @(negedge clk);
        check("wd_err_sticky", err_o, 1);
        send_cmd(0);
        check("wd_err_cleared", err_o, 0);
        @(negedge clk);
`else
        repeat (100) @(negedge clk);
        check("nowd_err", err_o, 0);
        check("nowd_busy", busy_o, 1);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("nowd_abort_busy", busy_o, 0);
`endif

        // Asynchronous reset mid-WAIT, then clean restart
        send_cmd(2);
        @(negedge clk);
        tile_done(1, 1'b0, 0);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("restart_ready", cmd_ready_o, 1);
        send_cmd(1);
        @(negedge clk);
        tile_done(1, 1'b1, 2);
        @(negedge clk);
        check("restart_ready_end", cmd_ready_o, 1);

        // Maximum tile count runs without wrap
        send_cmd(255);
        @(negedge clk);
        for (int i = 1; i <= 255; i++) tile_done(i, i == 255, 0);
        @(negedge clk);
        check("max_cnt_hold", tile_cnt_o, 255);
        check("max_ready", cmd_ready_o, 1);

        repeat (2) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
